// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Store-checker byte addresses and the pass data word
  localparam logic [31:0] CHK_PASS_ADR    = 32'd100;
  localparam logic [31:0] CHK_PASS_DATA   = 32'd7;
  localparam logic [31:0] CHK_SCRATCH_ADR = 32'd96;

  // Replace only the byte lanes selected by be; other lanes keep old_w
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with a byte-lane write port and a registered, enable-gated read port.
// Latency: write lands on the clock edge; read data appears one edge after re.
// Backpressure: none; the controller decides when to read and write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe,
  input  logic          re,
  input  logic          rzero,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, rdata_d;

  // Storage is deliberately not reset; only enabled lanes are updated
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= byte_merge(mem[waddr], wdata, wbe);
  end

  // Read register only moves on a read; rzero forces an out-of-range load to 0
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = rzero ? 32'd0 : mem[raddr];
  end

  // Read register, cleared by reset, holds between loads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= 32'd0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory responder: one load/store at a time, Stall held for LATENCY cycles.
// Latency: LATENCY stall cycles then one DONE cycle; ReadData loads entering DONE, stores commit leaving DONE.
// Backpressure: Stall holds the requester; dropping the request during WAIT aborts with no side effects.
// Optional feature macro DMEM_CHECK_EN: store checker driving Pass/Fail (tied 0 when undefined).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrErr,
  output logic        Pass,
  output logic        Fail
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        store_q, store_d;
  logic        addr_err_q, addr_err_d;

  logic        req;
  logic        enter_done;
  logic        commit;
  logic        cur_store;
  logic        cur_in_range;
  logic        lat_in_range;
  logic [29:0] cur_idx;
  logic        unused_adr_lsb;

  // Byte offset within the word has no meaning for a word memory
  assign unused_adr_lsb = ^DataAdr[1:0];

  // Both strobes high counts as a store
  assign req = MemRead | MemWrite;

  // Next-state logic. The counter is loaded with LATENCY-1 and the FSM leaves
  // WAIT on the cycle the decrement reaches zero, so Stall spans exactly
  // LATENCY cycles (the IDLE request cycle plus LATENCY-1 WAIT cycles).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    store_d = store_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = DataAdr[31:2];
          wdata_d = WriteData;
          be_d    = ByteEn;
          store_d = MemWrite;
          cnt_d   = CNT_INIT;
          state_d = (CNT_INIT == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          // flush: abandon the access, nothing written, no flag touched
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // For LATENCY=1 DONE is entered straight from IDLE, before anything is
  // latched, so the read side looks at the live inputs in that case.
  always_comb begin
    cur_idx      = (state_q == IDLE) ? DataAdr[31:2] : idx_q;
    cur_store    = (state_q == IDLE) ? MemWrite : store_q;
    cur_in_range = (cur_idx < 30'(DEPTH_WORDS));
    lat_in_range = (idx_q < 30'(DEPTH_WORDS));
    enter_done   = (state_d == DONE);
    commit       = (state_q == DONE) && store_q && lat_in_range;
    addr_err_d   = addr_err_q | (enter_done & ~cur_in_range);
  end

  // Controller registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= 30'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      store_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      store_q    <= store_d;
      addr_err_q <= addr_err_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (commit),
    .waddr (idx_q[AW-1:0]),
    .wdata (wdata_q),
    .wbe   (be_q),
    .re    (enter_done & ~cur_store),
    .rzero (~cur_in_range),
    .raddr (cur_idx[AW-1:0]),
    .rdata (ReadData)
  );

  // Stall is gated by reset so a request held during reset is not reflected
  assign Stall   = reset & (((state_q == IDLE) & req) | (state_q == WAIT));
  assign AddrErr = addr_err_q;

`ifdef DMEM_CHECK_EN
  localparam logic [29:0] CHK_PASS_IDX    = CHK_PASS_ADR[31:2];
  localparam logic [29:0] CHK_SCRATCH_IDX = CHK_SCRATCH_ADR[31:2];

  logic pass_q, pass_d;
  logic fail_q, fail_d;
  logic hit_pass, hit_scratch;

  // Classify each committed store; Fail wins and blocks Pass from then on
  always_comb begin
    hit_pass    = (idx_q == CHK_PASS_IDX) && (wdata_q == CHK_PASS_DATA);
    hit_scratch = (idx_q == CHK_SCRATCH_IDX);
    pass_d      = pass_q | (commit & hit_pass & ~fail_q);
    fail_d      = fail_q | (commit & ~hit_pass & ~hit_scratch);
  end

  // Sticky checker flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign Pass = pass_q;
  assign Fail = fail_q;
`else
  assign Pass = 1'b0;
  assign Fail = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a transaction-level reference model.
// Latency: model expects LAT stall cycles then one DONE cycle per access.
// Backpressure: bench holds requests through Stall, and sometimes drops them mid-WAIT.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic        Stall, AddrErr, Pass, Fail;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ByteEn    (ByteEn),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .AddrErr   (AddrErr),
    .Pass      (Pass),
    .Fail      (Fail)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // Reference model state
  logic        exp_stall = 1'b0;
  logic        exp_err   = 1'b0;
  logic        exp_pass  = 1'b0;
  logic        exp_fail  = 1'b0;
  logic [31:0] exp_rd    = 32'd0;
  logic [31:0] mem_m [DEPTH];
  logic [7:0]  stall_hist = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      stall_hist = {stall_hist[6:0], Stall};
      check("stall",    32'(Stall),   32'(exp_stall));
      check("readdata", ReadData,     exp_rd);
      check("addrerr",  32'(AddrErr), 32'(exp_err));
      check("pass",     32'(Pass),    32'(exp_pass));
      check("fail",     32'(Fail),    32'(exp_fail));
    end
  end

  // Store-checker rules applied to a committed store
  task automatic model_checker(input logic [29:0] idx, input logic [31:0] dat);
`ifdef DMEM_CHECK_EN
    if (idx == 30'(100 / 4) && dat == 32'd7) begin
      if (!exp_fail) exp_pass = 1'b1;
    end else if (idx != 30'(96 / 4)) begin
      exp_fail = 1'b1;
    end
`else
    if (idx == 30'd0 && dat == 32'd0) exp_pass = 1'b0;
`endif
  endtask

  // One access; called at posedge+1. abort_at in 1..LAT-1 drops the request in that WAIT cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] be, input int abort_at);
    logic [29:0] idx;
    bit          inr;
    idx = adr[31:2];
    inr = (idx < 30'(DEPTH));
    MemRead = rd; MemWrite = wr; DataAdr = adr; WriteData = dat; ByteEn = be;
    for (int c = 0; c < LAT; c++) begin
      if (c >= 1) begin
        // address/data changes after the request cycle must be ignored
        DataAdr = $urandom; WriteData = $urandom; ByteEn = 4'($urandom);
      end
      if (abort_at > 0 && c == abort_at) begin
        MemRead = 1'b0; MemWrite = 1'b0;
      end
      exp_stall = 1'b1;
      @(posedge clk); #1;
      if (abort_at > 0 && c == abort_at) begin
        exp_stall = 1'b0;
        return;
      end
    end
    // DONE cycle
    exp_stall = 1'b0;
    if (!wr) exp_rd = inr ? mem_m[idx] : 32'd0;
    if (!inr) exp_err = 1'b1;
    @(posedge clk); #1;
    if (wr && inr) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = dat[8*b +: 8];
      model_checker(idx, dat);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    MemRead = 1'b0; MemWrite = 1'b0; exp_stall = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_adr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int ab;
    // Reset held with a store request present
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b1;
    DataAdr = 32'h20; WriteData = 32'hFFFF_FFFF; ByteEn = 4'hF;
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall",    32'(Stall),   32'd0);
    check("rst_readdata", ReadData,     32'd0);
    check("rst_addrerr",  32'(AddrErr), 32'd0);
    check("rst_pass",     32'(Pass),    32'd0);
    check("rst_fail",     32'(Fail),    32'd0);
    MemWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Checker directed sequence: scratch then pass
    access(0, 1, 32'd96,  32'd3, 4'hF, 0);
    access(0, 1, 32'd100, 32'd7, 4'hF, 0);
`ifdef DMEM_CHECK_EN
    check("chk_pass_set", 32'(Pass), 32'd1);
    check("chk_fail_clr", 32'(Fail), 32'd0);
`else
    check("chk_pass_tied", 32'(Pass), 32'd0);
    check("chk_fail_tied", 32'(Fail), 32'd0);
`endif

    // Fill every word so later loads are fully defined
    for (int i = 0; i < DEPTH; i++) access(0, 1, 32'(i * 4), $urandom, 4'hF, 0);

    // Full-word store then load, stall shape 1,1,0
    access(0, 1, 32'h20, 32'h1234_5678, 4'hF, 0);
    check("store_stall_shape", 32'(stall_hist[2:0]), 32'b110);
    access(1, 0, 32'h20, 32'd0, 4'h0, 0);
    check("load_full", ReadData, 32'h1234_5678);

    // Single-lane store
    access(0, 1, 32'h20, 32'hAABB_CCDD, 4'b0001, 0);
    access(1, 0, 32'h22, 32'd0, 4'h0, 0);
    check("load_lane0", ReadData, 32'h1234_56DD);

    // Aborted store leaves prior value
    access(0, 1, 32'h24, 32'h0BAD_F00D, 4'hF, 0);
    access(0, 1, 32'h24, 32'hFFFF_FFFF, 4'hF, 1);
    check("abort_idle", 32'(Stall), 32'd0);
    access(1, 0, 32'h24, 32'd0, 4'h0, 0);
    check("abort_nowrite", ReadData, 32'h0BAD_F00D);

    // Out-of-range store and load
    access(0, 1, 32'h0, 32'hCAFE_F00D, 4'hF, 0);
    check("oor_err_before", 32'(AddrErr), 32'd0);
    access(0, 1, 32'h400, 32'h0000_DEAD, 4'hF, 0);
    check("oor_err_set", 32'(AddrErr), 32'd1);
    access(1, 0, 32'h0, 32'd0, 4'h0, 0);
    check("oor_no_alias", ReadData, 32'hCAFE_F00D);
    access(1, 0, 32'h400, 32'd0, 4'h0, 0);
    check("oor_load_zero", ReadData, 32'd0);

    // Reset mid-access: store in flight must not commit
    access(0, 1, 32'h30, 32'h1111_1111, 4'hF, 0);
    MemWrite = 1'b1; DataAdr = 32'h30; WriteData = 32'h2222_2222; ByteEn = 4'hF;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_stall = 1'b0; exp_rd = 32'd0; exp_err = 1'b0; exp_pass = 1'b0; exp_fail = 1'b0;
    @(posedge clk); #1;
    check("midrst_stall",   32'(Stall),   32'd0);
    check("midrst_addrerr", 32'(AddrErr), 32'd0);
    MemWrite = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    access(0, 1, 32'd104, 32'd5, 4'hF, 0);
`ifdef DMEM_CHECK_EN
    check("chk_fail_set", 32'(Fail), 32'd1);
    check("chk_pass_blk", 32'(Pass), 32'd0);
`else
    check("chk_fail_tied2", 32'(Fail), 32'd0);
`endif
    access(1, 0, 32'h30, 32'd0, 4'h0, 0);
    check("midrst_nowrite", ReadData, 32'h1111_1111);

    // Randomized traffic, back-to-back and with gaps and aborts
    repeat (300) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      kind = $urandom_range(0, 2);
      ab   = (LAT > 1 && $urandom_range(0, 7) == 0) ? $urandom_range(1, LAT - 1) : 0;
      access(kind != 1, kind != 0, rand_adr(), $urandom, 4'($urandom), ab);
    end
    idle(2);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
